// File: rtl/maxpool2d_relu_fp32_pkg.sv
// Shared fp32 helpers for the 2x2 max-pool block.
// MAXPOOL_RELU_EN selects ReLU clamp + magnitude compare; otherwise a full signed fp32 max.
package maxpool2d_relu_fp32_pkg;

  localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
  localparam int          FP32_SIGN_BIT = 31;

  // Row parity: even rows fill the line buffer, odd rows emit pooled results.
  typedef enum logic {
    PH_FILL = 1'b0,
    PH_EMIT = 1'b1
  } phase_e;

  function automatic logic [31:0] fp32_relu(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[FP32_SIGN_BIT] ? FP32_ZERO : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] fp32_max(input logic [31:0] a, input logic [31:0] b);
`ifdef MAXPOOL_RELU_EN
    // Both operands are already clamped to non-negative, so magnitude order is value order.
    return (a[30:0] >= b[30:0]) ? a : b;
`else
    if (a[FP32_SIGN_BIT] != b[FP32_SIGN_BIT]) begin
      return a[FP32_SIGN_BIT] ? b : a;
    end else if (!a[FP32_SIGN_BIT]) begin
      return (a[30:0] >= b[30:0]) ? a : b;
    end else begin
      return (a[30:0] <= b[30:0]) ? a : b;
    end
`endif
  endfunction

endpackage

// File: rtl/maxpool2d_relu_fp32_line_buffer.sv
// One-row store of horizontal maxima: one write port, one asynchronous read port, no reset.
// Behaviour does not depend on MAXPOOL_RELU_EN.
module pool_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 28,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool2d_relu_fp32.sv
// Streaming 2x2 stride-2 max-pool over a WIDTH x WIDTH fp32 raster, optional fused ReLU
// (MAXPOOL_RELU_EN). Accepts a sample on every valid_in cycle; outputs are registered.
module maxpool2d_relu_fp32
  import maxpool2d_relu_fp32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]         col_q, col_d, row_q, row_d;
  phase_e                phase_q, phase_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, data_q, data_d;
  logic [DATA_WIDTH-1:0] sample, hmax, lb_rdata;
  logic                  valid_q, valid_d, fd_q, fd_d;
  logic                  col_wrap, lb_we;
  logic [AW-1:0]         lb_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= PH_FILL;
      data_q  <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
    end
  end

  // Always written on an even column before the odd column reads it.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  // Phase tracks the row LSB; it only flips when a row completes.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_FILL: if (col_wrap) phase_d = PH_EMIT;
      PH_EMIT: if (col_wrap) phase_d = PH_FILL;
      default: phase_d = PH_FILL;
    endcase
  end

  always_comb begin
    sample   = fp32_relu(data_in);
    hmax     = fp32_max(hold_q, sample);
    col_wrap = valid_in && (col_q == LAST);
    lb_idx   = AW'(col_q >> 1);
    col_d    = col_q;
    row_d    = row_q;
    hold_d   = hold_q;
    lb_we    = 1'b0;
    data_d   = data_q;
    valid_d  = 1'b0;
    fd_d     = 1'b0;
    if (valid_in) begin
      col_d = col_wrap ? '0 : col_q + 1'b1;
      if (col_wrap) row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      if (!col_q[0]) begin
        hold_d = sample;
      end else if (phase_q == PH_FILL) begin
        lb_we = 1'b1;
      end else begin
        data_d  = fp32_max(lb_rdata, hmax);
        valid_d = 1'b1;
        fd_d    = (row_q == LAST) && (col_q == LAST);
      end
    end
  end

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HALF),
    .AW         (AW)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_idx),
    .wdata_i (hmax),
    .raddr_i (lb_idx),
    .rdata_o (lb_rdata)
  );

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_maxpool2d_relu_fp32.sv
// Scoreboard bench for maxpool2d_relu_fp32 at WIDTH=56; honours MAXPOOL_RELU_EN like the RTL.
module tb_maxpool2d_relu_fp32;

  localparam int W    = 56;
  localparam int HALF = W / 2;
  localparam int NW   = HALF * HALF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;
  int strobes_in_frame = 0;
  int fd_total = 0;

  logic [31:0] exp_q[$];
  logic        exp_fd_q[$];
  logic [31:0] fr   [W*W];
  logic [31:0] fr_b [W*W];

  maxpool2d_relu_fp32 #(.DATA_WIDTH(32), .WIDTH(W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: map fp32 to a key whose unsigned order is numeric order.
  function automatic logic [31:0] relu_m(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] key_m(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] max_m(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ra, rb;
    ra = relu_m(a);
    rb = relu_m(b);
    return (key_m(rb) > key_m(ra)) ? rb : ra;
  endfunction

  function automatic logic [31:0] known_exp(input int wc);
    case (wc)
      0:       return 32'h4000_0000;
`ifdef MAXPOOL_RELU_EN
      1:       return 32'h0000_0000;
      2:       return 32'h0000_0000;
`else
      1:       return 32'hBF80_0000;
      2:       return 32'hBF00_0000;
`endif
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic gen_frame();
    for (int i = 0; i < W*W; i++) begin
      case ($urandom_range(0, 9))
        0:       fr[i] = 32'h8000_0000;
        1:       fr[i] = 32'h0000_0000;
        2:       fr[i] = (i > 0) ? fr[i-1] : 32'h3F80_0000;
        default: fr[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      endcase
    end
  endtask

  task automatic set_special();
    fr[0] = 32'h3F80_0000; fr[1] = 32'h4000_0000; fr[W]   = 32'h3F00_0000; fr[W+1] = 32'h3E80_0000;
    fr[2] = 32'hBF80_0000; fr[3] = 32'hBF80_0000; fr[W+2] = 32'hBF80_0000; fr[W+3] = 32'hBF80_0000;
    fr[4] = 32'hC000_0000; fr[5] = 32'hBF00_0000; fr[W+4] = 32'hBF80_0000; fr[W+5] = 32'hC080_0000;
    fr[6] = 32'h8000_0000; fr[7] = 32'h0000_0000; fr[W+6] = 32'hBF80_0000; fr[W+7] = 32'hBF80_0000;
  endtask

  task automatic push_frame_exp(input bit known);
    int          base;
    logic [31:0] m;
    for (int wr = 0; wr < HALF; wr++) begin
      for (int wc = 0; wc < HALF; wc++) begin
        base = 2*wr*W + 2*wc;
        m = max_m(max_m(fr[base], fr[base+1]), max_m(fr[base+W], fr[base+W+1]));
        if (known && wr == 0 && wc < 4) m = known_exp(wc);
        exp_q.push_back(m);
        exp_fd_q.push_back(wr == HALF-1 && wc == HALF-1);
      end
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [31:0] d);
    valid_in = v;
    data_in  = d;
    @(negedge clk);
  endtask

  // stop_at < 0 streams the whole frame; otherwise stops before that sample index.
  task automatic drive_frame(input int gap_pct, input int stop_at, input bit lat_chk);
    for (int i = 0; i < W*W; i++) begin
      if (i == stop_at) return;
      while ($urandom_range(1, 100) <= gap_pct) drive_cycle(1'b0, $urandom);
      drive_cycle(1'b1, fr[i]);
      if (lat_chk && i == W)   chk("lat_even", {31'b0, valid_out}, 32'd0);
      if (lat_chk && i == W+1) chk("lat_odd", {31'b0, valid_out}, 32'd1);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e, m;
    logic        f;
    if (!rst) begin
      strobes_in_frame = 0;
    end else begin
      if (frame_done && !valid_out) chk("fd_alone", {31'b0, frame_done}, 32'd0);
      if (valid_out) begin
        strobes_in_frame++;
        if (exp_q.size() == 0) begin
          chk("stray", {31'b0, valid_out}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          f = exp_fd_q.pop_front();
          m = 32'hFFFF_FFFF;
`ifndef MAXPOOL_RELU_EN
          if (e[30:0] == 31'd0) m = 32'h7FFF_FFFF;
`endif
          chk("data", data_out & m, e & m);
          chk("fd", {31'b0, frame_done}, {31'b0, f});
        end
        if (frame_done) begin
          fd_total++;
          chk("fd_pos", strobes_in_frame, NW);
          strobes_in_frame = 0;
        end
      end
    end
  end

  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_fd", {31'b0, frame_done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Three back-to-back frames, the first carrying the known-answer windows.
    gen_frame();
    set_special();
    push_frame_exp(1'b1);
    drive_frame(0, -1, 1'b1);
    gen_frame();
    fr_b = fr;
    push_frame_exp(1'b0);
    drive_frame(0, -1, 1'b0);
    gen_frame();
    push_frame_exp(1'b0);
    drive_frame(0, -1, 1'b0);
    repeat (3) drive_cycle(1'b0, 32'h0);
    chk("fd_cnt3", fd_total, 32'd3);

    // Same data as frame two, with valid_in low roughly half the time.
    fr = fr_b;
    push_frame_exp(1'b0);
    drive_frame(50, -1, 1'b0);
    repeat (3) drive_cycle(1'b0, 32'h0);
    chk("fd_cnt4", fd_total, 32'd4);

    // Abandon a frame at row 3 col 10, then stream a fresh frame.
    gen_frame();
    push_frame_exp(1'b0);
    drive_frame(0, 3*W + 10, 1'b0);
    drive_cycle(1'b0, 32'h0);
    rst = 1'b0;
    repeat (2) drive_cycle(1'b0, $urandom);
    chk("mid_rst_data", data_out, 32'h0);
    chk("mid_rst_valid", {31'b0, valid_out}, 32'd0);
    chk("mid_rst_fd", {31'b0, frame_done}, 32'd0);
    exp_q.delete();
    exp_fd_q.delete();
    rst = 1'b1;
    gen_frame();
    push_frame_exp(1'b0);
    drive_frame(0, -1, 1'b0);
    repeat (4) drive_cycle(1'b0, 32'h0);

    chk("fd_total", fd_total, 32'd5);
    chk("drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maxpool2d_relu_fp32.md
# maxpool2d_relu_fp32

Streaming 2×2 / stride-2 max-pool with fused ReLU for IEEE-754 single-precision feature maps. It sits directly downstream of each `featuremap_conv2d_*_filter*` block and consumes that block's `data_out`/`valid_out` raster stream of WIDTH×WIDTH biased convolution results. It emits a (WIDTH/2)×(WIDTH/2) pooled map, in raster order, to the next layer's input FIFO. There is no backpressure: the block accepts one sample on every cycle that `valid_in` is high.

## Interface
- DATA_WIDTH, 32: sample width; fixed fp32. No other value is supported.
- WIDTH, 56: input map side length in samples. Must be even and ≥2. Output side is WIDTH/2.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  fp32 sample from the conv/bias stage.
- valid_in  in  1  qualifies data_in. Gaps of any length are legal.
- data_out  out  DATA_WIDTH  pooled fp32 result.
- valid_out  out  1  one-cycle strobe qualifying data_out. Intended as the wrreq of the next FIFO.
- frame_done  out  1  one-cycle pulse coincident with the last valid_out of a frame.

## Operation
- **Counters.**
  - col counts 0..WIDTH-1 and row counts 0..WIDTH-1.
  - Both advance only on valid_in.
  - col wraps to 0 after WIDTH-1 and increments row at that point. row wraps to 0 after WIDTH-1 (frame end).
  - The next frame starts immediately with no idle requirement.
- **ReLU.**
  - Applied to every accepted sample before any comparison.
  - If sign bit = 1 (includes -0.0 and negative values), the sample is replaced by 32'h0000_0000.
- **Compare.**
  - After ReLU every operand is non-negative, so max() is an unsigned compare on bits [30:0].
  - On a tie, either operand may be selected (the bit patterns are identical).
  - NaN inputs are not handled specially.
- **Horizontal max.**
  - On even col, the sample is stored in a hold register.
  - On odd col, hmax = max(hold, sample).
- **Line buffer.**
  - WIDTH/2 entries of DATA_WIDTH bits, indexed by col>>1.
  - On even row + odd col, hmax is written to the buffer.
  - On odd row + odd col, data_out is set to max(linebuf[col>>1], hmax) and valid_out is asserted.
- **Frame done.** frame_done asserts together with the valid_out produced by the sample at row=WIDTH-1, col=WIDTH-1.
- **States.** The datapath is a two-phase control held as the row LSB:
  - FILL (even row): writes the line buffer, produces no output.
  - EMIT (odd row): reads the line buffer and produces output.
  - Transitions occur only at col wrap.
- **Reset.** Reset mid-frame discards the partial frame: counters go to 0 and the next accepted sample is treated as (row 0, col 0). Line-buffer and hold contents are not reset; they are always overwritten before they are read.

## Timing
- **Reset values:** data_out = 0, valid_out = 0, frame_done = 0, col = 0, row = 0.
- **Latency:** data_out, valid_out and frame_done are registered. They update 1 cycle after the rising edge that accepts the bottom-right sample of a 2×2 window.
- **Output strobes:** valid_out is high for exactly 1 cycle per window. A frame produces exactly (WIDTH/2)² strobes.
- **Back-to-back input:** with a continuous valid_in, output appears every 2nd cycle during EMIT rows and never during FILL rows.
- **Line-buffer access:** the read and write of the same line-buffer entry never occur in the same cycle, because they are separated by a full row. A single-port RAM or register array is acceptable.

## Configuration
- `MAXPOOL_RELU_EN`
  - Defined: the ReLU clamp is applied as described above.
  - Undefined: no clamp, and max() becomes a full signed fp32 compare:
    - If the signs differ, the positive operand wins.
    - If both are positive, the larger magnitude wins.
    - If both are negative, the smaller magnitude wins.
    - -0.0 and +0.0 compare equal.
  - All other behaviour and all timing are identical in both builds.

## Structure
- **Shared package:** `FP32_ZERO`, `FP32_SIGN_BIT` (31), and the `fp32_max` function selected by `MAXPOOL_RELU_EN`.
- **Sub-module:** `pool_line_buffer`, a WIDTH/2-deep, DATA_WIDTH-wide array with one write port and one read port and no reset.
- **Top level:** holds the counters, hold register, compare logic and output registers.

## Test plan
- **Basic window (WIDTH=4):** frame samples 1.0 (3F800000), 2.0 (40000000), 0.5, 0.25 arranged as a 2×2 window, plus other windows. Required: the first valid_out carries 40000000, one cycle after the row-1 col-1 sample.
- **ReLU (`MAXPOOL_RELU_EN` defined):** a window of all -1.0 (BF800000) gives data_out = 00000000. With the macro undefined, the same window gives BF800000.
- **Count and frame_done:** continuous valid_in for 3 frames at WIDTH=56. Required: 784 valid_out per frame, and frame_done exactly 3 times, each on the 784th strobe.
- **Gapped input:** valid_in randomly low 50% of cycles. Output values are identical to the gap-free run; only the timing stretches.
- **Mid-frame reset:** assert rst low at row 3, col 10, then stream a fresh frame. Required: outputs match a clean frame, with no stale strobes.
- **Signed compare (macro undefined):** window {-2.0, -0.5, -1.0, -4.0} gives BF000000. Window {-0.0, +0.0, -1.0, -1.0} gives a zero of either sign.
